// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Purpose  : Iterative multiply/divide unit for the execute stage. A single
//             shift/add-subtract datapath serves MULT, MULTU, DIV and DIVU,
//             one result bit per cycle. The result is packed {hi, lo}:
//             multiply -> {product_hi, product_lo},
//             divide   -> {remainder, quotient}.
//  Ports    : clk, rst           clock, synchronous active-high reset
//             start_i            request pulse, sampled only in IDLE
//             annul_i            abort the current operation (CALC/FIX)
//             op_div_i           1 = divide, 0 = multiply
//             signed_i           1 = two's-complement operands
//             opdata1_i          multiplicand / dividend
//             opdata2_i          multiplier / divisor
//             result_o           {hi, lo}; held until the next completion
//             ready_o            one-cycle result-valid pulse
//             busy_o             high in every state other than IDLE
//             div_zero_o         divide had a zero divisor (valid with ready_o)
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               op_div_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_b;        // multiplicand (mul) or divisor (div), magnitude
  logic [2*WIDTH-1:0]   r_acc;      // {hi, lo} working accumulator
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;
  logic                 r_div_zero;

  logic                 w_start;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic [WIDTH-1:0]     w_acc_hi;
  logic [WIDTH-1:0]     w_acc_lo;
  logic [WIDTH:0]       w_madd;
  logic [WIDTH:0]       w_dshift;
  logic                 w_dok;
  logic [WIDTH-1:0]     w_dsub;
  logic [2*WIDTH-1:0]   w_fix;

  assign w_start  = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_a_neg  = signed_i && opdata1_i[WIDTH-1];
  assign w_b_neg  = signed_i && opdata2_i[WIDTH-1];
  assign w_abs1   = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_abs2   = w_b_neg ? -opdata2_i : opdata2_i;
  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];

  // Multiply step: add the multiplicand into the high half when the current
  // multiplier LSB is set; the carry is kept and shifted back in from the top.
  assign w_madd = {1'b0, w_acc_hi} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};

  // Divide step: the partial remainder is WIDTH+1 bits wide after the shift.
  // When the subtraction succeeds the true difference is below the divisor,
  // so a WIDTH-bit modular subtract yields it exactly.
  assign w_dshift = {w_acc_hi, w_acc_lo[WIDTH-1]};
  assign w_dok    = w_dshift[WIDTH] || (w_dshift[WIDTH-1:0] >= r_b);
  assign w_dsub   = w_dshift[WIDTH-1:0] - r_b;

  always_comb begin
    w_fix = r_acc;
    if (r_div) begin
      w_fix[WIDTH-1:0]       = r_neg_q ? -w_acc_lo : w_acc_lo;
      w_fix[2*WIDTH-1:WIDTH] = r_neg_r ? -w_acc_hi : w_acc_hi;
    end else if (r_neg_q) begin
      w_fix = -r_acc;
    end
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          // A zero divisor skips the iterations entirely.
          w_state_nxt = (op_div_i && (opdata2_i == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (annul_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = annul_i ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_b        <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_ready    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_div   <= op_div_i;
            r_cnt   <= CNT_W'(WIDTH);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= 1'b0;
            if (op_div_i && (opdata2_i == '0)) begin
              // Raw dividend as remainder, all-ones quotient, no sign fix-up.
              r_acc   <= {opdata1_i, {WIDTH{1'b1}}};
              r_b     <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_dz    <= 1'b1;
            end else if (op_div_i) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs1};
              r_b   <= w_abs2;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs2};
              r_b   <= w_abs1;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_div) begin
            r_acc <= w_dok ? {w_dsub, w_acc_lo[WIDTH-2:0], 1'b1}
                           : {w_dshift[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0};
          end else begin
            r_acc <= {w_madd, w_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!annul_i) begin
            r_result <= w_fix;
          end
        end
        S_DONE: begin
          r_ready    <= 1'b1;
          r_div_zero <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign div_zero_o = r_div_zero;
  assign busy_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_iter
//  Purpose  : Self-checking bench for muldiv_iter at WIDTH=32 and WIDTH=8.
//             Directed vectors with hand-computed results plus a short
//             random sweep against a behavioural arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

  logic        clk;
  logic        rst;

  logic        d32_start, d32_annul, d32_div, d32_sg;
  logic [31:0] d32_a, d32_b;
  logic [63:0] d32_res;
  logic        d32_rdy, d32_busy, d32_dz;

  logic        d8_start, d8_annul, d8_div, d8_sg;
  logic [7:0]  d8_a, d8_b;
  logic [15:0] d8_res;
  logic        d8_rdy, d8_busy, d8_dz;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_iter #(.WIDTH(32)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (d32_start),
    .annul_i    (d32_annul),
    .op_div_i   (d32_div),
    .signed_i   (d32_sg),
    .opdata1_i  (d32_a),
    .opdata2_i  (d32_b),
    .result_o   (d32_res),
    .ready_o    (d32_rdy),
    .busy_o     (d32_busy),
    .div_zero_o (d32_dz)
  );

  muldiv_iter #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (d8_start),
    .annul_i    (d8_annul),
    .op_div_i   (d8_div),
    .signed_i   (d8_sg),
    .opdata1_i  (d8_a),
    .opdata2_i  (d8_b),
    .result_o   (d8_res),
    .ready_o    (d8_rdy),
    .busy_o     (d8_busy),
    .div_zero_o (d8_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic
  function automatic logic [63:0] model32(input bit dv, input bit sg,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = $signed(a);
    sb = $signed(b);
    if (dv) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sg) begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
    end
    if (sg) begin
      p = sa * sb;
      return p;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [15:0] model8(input bit dv, input bit sg,
                                         input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r, p;
    sa = $signed(a);
    sb = $signed(b);
    if (dv) begin
      if (b == 8'd0) return {a, 8'hFF};
      if (sg) begin
        q = sa / sb;
        r = sa % sb;
        return {r[7:0], q[7:0]};
      end
      return {a % b, a / b};
    end
    if (sg) begin
      p = sa * sb;
      return p[15:0];
    end
    return {8'd0, a} * {8'd0, b};
  endfunction

  // Drivers: called at a negedge; start is applied immediately and the
  // operands are scrambled after the start edge. Latency k means ready_o was
  // first seen in the cycle following start edge + k; -1 means no ready_o.
  task automatic run32(input bit dv, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input bit poke,
                       output logic [63:0] res, output logic dz, output int lat,
                       output int busy_n, output logic rdy_after);
    d32_start = 1'b1; d32_div = dv; d32_sg = sg; d32_a = a; d32_b = b;
    lat = -1; busy_n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      d32_start = (poke && k == 5);
      d32_div = ~dv; d32_sg = ~sg; d32_a = $urandom; d32_b = $urandom;
      if (d32_rdy) begin lat = k; break; end
      if (d32_busy) busy_n++;
    end
    d32_start = 1'b0;
    res = d32_res; dz = d32_dz;
    @(negedge clk);
    rdy_after = d32_rdy;
  endtask

  task automatic run8(input bit dv, input bit sg, input logic [7:0] a,
                      input logic [7:0] b, input int annul_k,
                      output logic [15:0] res, output logic dz, output int lat,
                      output int busy_n, output logic rdy_after);
    d8_start = 1'b1; d8_div = dv; d8_sg = sg; d8_a = a; d8_b = b;
    lat = -1; busy_n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      d8_start = 1'b0;
      d8_annul = (k == annul_k);
      d8_div = ~dv; d8_sg = ~sg; d8_a = 8'($urandom); d8_b = 8'($urandom);
      if (d8_rdy) begin lat = k; break; end
      if (d8_busy) busy_n++;
    end
    d8_annul = 1'b0;
    res = d8_res; dz = d8_dz;
    @(negedge clk);
    rdy_after = d8_rdy;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (d32_res !== 64'd0) begin n_fail++; $display("FAIL reset_res32: got %h exp 0", d32_res); end
    n_checks++; if (d32_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_rdy32: got %b exp 0", d32_rdy); end
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy32: got %b exp 0", d32_busy); end
    n_checks++; if (d32_dz !== 1'b0)   begin n_fail++; $display("FAIL reset_dz32: got %b exp 0", d32_dz); end
    n_checks++; if (d8_res !== 16'd0)  begin n_fail++; $display("FAIL reset_res8: got %h exp 0", d8_res); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy32: got %b exp 0", d32_busy); end
  endtask

  task automatic test_mul();
    logic [63:0] r; logic dz, ra; int lat, bn;
    run32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_res: got %h exp fffffffe00000001", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_lat: got %0d exp 34", lat); end
    n_checks++; if (bn !== 34)  begin n_fail++; $display("FAIL multu_busy: got %0d exp 34", bn); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL multu_ready_width: got %b exp 0", ra); end
    run32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_res: got %h exp ffffffffffffffeb", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL mult_dz: got %b exp 0", dz); end
    run32(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'd0) begin n_fail++; $display("FAIL mult_zero_res: got %h exp 0", r); end
    n_checks++; if (lat !== 34)  begin n_fail++; $display("FAIL mult_zero_lat: got %0d exp 34", lat); end
  endtask

  task automatic test_div();
    logic [63:0] r; logic dz, ra; int lat, bn;
    run32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg_res: got %h exp fffffffffffffffd", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_lat: got %0d exp 34", lat); end
    run32(1'b1, 1'b0, 32'd7, 32'd2, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0001_0000_0003) begin n_fail++; $display("FAIL divu_res: got %h exp 0000000100000003", r); end
    run32(1'b1, 1'b1, 32'd0, 32'd5, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'd0) begin n_fail++; $display("FAIL div_zero_dividend: got %h exp 0", r); end
    n_checks++; if (lat !== 34)  begin n_fail++; $display("FAIL div_zero_dividend_lat: got %0d exp 34", lat); end
  endtask

  task automatic test_div_zero();
    logic [63:0] r; logic [15:0] r8; logic dz, ra; int lat, bn;
    run32(1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h1234_5678_FFFF_FFFF) begin n_fail++; $display("FAIL dz_div_res: got %h exp 12345678ffffffff", r); end
    n_checks++; if (lat !== 2)  begin n_fail++; $display("FAIL dz_div_lat: got %0d exp 2", lat); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_div_flag: got %b exp 1", dz); end
    n_checks++; if (bn !== 2)   begin n_fail++; $display("FAIL dz_div_busy: got %0d exp 2", bn); end
    run32(1'b1, 1'b0, 32'h1234_5678, 32'd0, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h1234_5678_FFFF_FFFF) begin n_fail++; $display("FAIL dz_divu_res: got %h exp 12345678ffffffff", r); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_divu_flag: got %b exp 1", dz); end
    run32(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0002_0000_000E) begin n_fail++; $display("FAIL dz_clear_res: got %h exp 000000020000000e", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dz_clear_flag: got %b exp 0", dz); end
    run8(1'b1, 1'b1, 8'h85, 8'h00, -1, r8, dz, lat, bn, ra);
    n_checks++; if (r8 !== 16'h85FF) begin n_fail++; $display("FAIL dz8_res: got %h exp 85ff", r8); end
    n_checks++; if (lat !== 2)  begin n_fail++; $display("FAIL dz8_lat: got %0d exp 2", lat); end
  endtask

  task automatic test_overflow();
    logic [63:0] r; logic [15:0] r8; logic dz, ra; int lat, bn;
    run32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL ovf32_res: got %h exp 0000000080000000", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL ovf32_dz: got %b exp 0", dz); end
    run8(1'b1, 1'b1, 8'h80, 8'hFF, -1, r8, dz, lat, bn, ra);
    n_checks++; if (r8 !== 16'h0080) begin n_fail++; $display("FAIL ovf8_res: got %h exp 0080", r8); end
  endtask

  task automatic test_annul();
    logic [63:0] r; logic [15:0] r8; logic dz, ra; int lat, bn;
    d32_start = 1'b1; d32_div = 1'b1; d32_sg = 1'b0; d32_a = 32'd1000; d32_b = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      d32_start = 1'b0;
    end
    d32_annul = 1'b1;           // seen at the edge ending the tenth CALC cycle
    @(negedge clk);
    d32_annul = 1'b0;
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL annul_busy: got %b exp 0", d32_busy); end
    n_checks++; if (d32_rdy !== 1'b0)  begin n_fail++; $display("FAIL annul_rdy: got %b exp 0", d32_rdy); end
    n_checks++; if (d32_res !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL annul_res_held: got %h exp 0000000080000000", d32_res); end
    run32(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0001_0000_014D) begin n_fail++; $display("FAIL annul_restart_res: got %h exp 000000010000014d", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL annul_restart_lat: got %0d exp 34", lat); end
    d32_start = 1'b1; d32_annul = 1'b1;
    @(negedge clk);
    d32_start = 1'b0; d32_annul = 1'b0;
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL annul_with_start: got busy %b exp 0", d32_busy); end
    run8(1'b0, 1'b0, 8'd12, 8'd11, 9, r8, dz, lat, bn, ra);
    n_checks++; if (r8 !== 16'h0084) begin n_fail++; $display("FAIL annul_done_res: got %h exp 0084", r8); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL annul_done_lat: got %0d exp 10", lat); end
  endtask

  task automatic test_start_ignored();
    logic [63:0] r; logic dz, ra; int lat, bn;
    run32(1'b0, 1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b1, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0000_0C37_4FA4) begin n_fail++; $display("FAIL busy_start_res: got %h exp 000000000c374fa4", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL busy_start_lat: got %0d exp 34", lat); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL busy_start_extra_ready: got %b exp 0", ra); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic dz, ra; int lat, bn;
    run32(1'b1, 1'b0, 32'h55, 32'd0, 1'b0, r, dz, lat, bn, ra);
    n_checks++; if (r !== 64'h0000_0055_FFFF_FFFF) begin n_fail++; $display("FAIL pre_reset_res: got %h exp 00000055ffffffff", r); end
    d32_start = 1'b1; d32_div = 1'b0; d32_sg = 1'b0; d32_a = 32'hFFFF_FFFF; d32_b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d32_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (d32_res !== 64'd0) begin n_fail++; $display("FAIL midrst_res: got %h exp 0", d32_res); end
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", d32_busy); end
    n_checks++; if (d32_dz !== 1'b0)   begin n_fail++; $display("FAIL midrst_dz: got %b exp 0", d32_dz); end
    n_checks++; if (d32_rdy !== 1'b0)  begin n_fail++; $display("FAIL midrst_rdy: got %b exp 0", d32_rdy); end
    @(negedge clk);
    n_checks++; if (d32_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_idle: got %b exp 0", d32_busy); end
  endtask

  task automatic test_w8();
    logic [15:0] r8; logic dz, ra; int lat, bn;
    run8(1'b0, 1'b1, 8'h80, 8'h80, -1, r8, dz, lat, bn, ra);
    n_checks++; if (r8 !== 16'h4000) begin n_fail++; $display("FAIL w8_mult_res: got %h exp 4000", r8); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL w8_mult_lat: got %0d exp 10", lat); end
    n_checks++; if (bn !== 10)  begin n_fail++; $display("FAIL w8_mult_busy: got %0d exp 10", bn); end
    run8(1'b1, 1'b1, 8'h81, 8'h05, -1, r8, dz, lat, bn, ra);
    n_checks++; if (r8 !== 16'hFEE7) begin n_fail++; $display("FAIL w8_div_res: got %h exp fee7", r8); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL w8_div_lat: got %0d exp 10", lat); end
  endtask

  task automatic test_random();
    logic [63:0] r, e; logic [15:0] r8, e8; logic dz, ra; int lat, bn;
    bit dv, sg; logic [31:0] a, b; logic [7:0] a8, b8;
    for (int i = 0; i < 100; i++) begin
      dv = 1'($urandom); sg = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      e = model32(dv, sg, a, b);
      run32(dv, sg, a, b, 1'b0, r, dz, lat, bn, ra);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL rnd32_res dv=%0d sg=%0d a=%h b=%h: got %h exp %h", dv, sg, a, b, r, e); end
      n_checks++; if (lat !== ((dv && b == 0) ? 2 : 34)) begin n_fail++; $display("FAIL rnd32_lat: got %0d", lat); end
      n_checks++; if (dz !== (dv && b == 0)) begin n_fail++; $display("FAIL rnd32_dz: got %b", dz); end
    end
    for (int i = 0; i < 500; i++) begin
      dv = 1'($urandom); sg = 1'($urandom);
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      e8 = model8(dv, sg, a8, b8);
      run8(dv, sg, a8, b8, -1, r8, dz, lat, bn, ra);
      n_checks++; if (r8 !== e8) begin n_fail++; $display("FAIL rnd8_res dv=%0d sg=%0d a=%h b=%h: got %h exp %h", dv, sg, a8, b8, r8, e8); end
      n_checks++; if (lat !== ((dv && b8 == 0) ? 2 : 10)) begin n_fail++; $display("FAIL rnd8_lat: got %0d", lat); end
      n_checks++; if (dz !== (dv && b8 == 0)) begin n_fail++; $display("FAIL rnd8_dz: got %b", dz); end
    end
  endtask

  initial begin
    rst = 1'b1;
    d32_start = 1'b0; d32_annul = 1'b0; d32_div = 1'b0; d32_sg = 1'b0; d32_a = '0; d32_b = '0;
    d8_start  = 1'b0; d8_annul  = 1'b0; d8_div  = 1'b0; d8_sg  = 1'b0; d8_a  = '0; d8_b  = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_annul();
    test_start_ignored();
    test_reset_mid();
    test_w8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
